// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants, packer state type and width helper for the IO packer
package io_pkg;

    localparam int IO_IN_W  = 4;
    localparam int IO_OUT_W = 16;

    typedef enum logic {
        PK_FILL = 1'b0,
        PK_HOLD = 1'b1
    } pk_state_t;

    // Width needed to hold a chunk count in the range 0..ratio.
    function automatic int pk_cnt_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/io_pack_extend.sv
// rtl/io_pack_extend.sv - zero/sign extension of a partially filled word (IO_PACKER_SIGN_EXT_EN selects sign)
module io_pack_extend
    import io_pkg::*;
#(
    parameter  int IN_W  = IO_IN_W,
    parameter  int OUT_W = IO_OUT_W,
    localparam int RATIO = OUT_W / IN_W,
    localparam int CW    = pk_cnt_w(OUT_W / IN_W)
) (
    input  logic [OUT_W-1:0] i_word,
    input  logic [CW-1:0]    i_cnt,
    input  logic             i_partial,
    output logic [OUT_W-1:0] o_word
);

    logic w_fill;

`ifdef IO_PACKER_SIGN_EXT_EN
    // Fill value is the MSB of the last real chunk.
    always_comb begin
        w_fill = 1'b0;
        for (int k = 0; k < RATIO; k++) begin
            if (i_cnt == CW'(k + 1)) begin
                w_fill = i_word[k*IN_W + IN_W - 1];
            end
        end
    end
`else
    assign w_fill = 1'b0;
`endif

    always_comb begin
        o_word = i_word;
        for (int j = 0; j < RATIO; j++) begin
            if (i_partial && (CW'(j) >= i_cnt)) begin
                o_word[j*IN_W +: IN_W] = {IN_W{w_fill}};
            end
        end
    end

endmodule

// File: rtl/io_nibble_packer.sv
// rtl/io_nibble_packer.sv - packs IN_W-bit chunks LSB-first into OUT_W-bit words with flush
// Flushed-word extension mode is chosen by IO_PACKER_SIGN_EXT_EN inside io_pack_extend.
module io_nibble_packer
    import io_pkg::*;
#(
    parameter  int IN_W  = IO_IN_W,
    parameter  int OUT_W = IO_OUT_W,
    localparam int RATIO = OUT_W / IN_W,
    localparam int CW    = pk_cnt_w(OUT_W / IN_W)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IN_W-1:0]  i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_flush,
    output logic [OUT_W-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [CW-1:0]    o_out_cnt
);

    pk_state_t        r_state;
    pk_state_t        w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [OUT_W-1:0] r_word;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_last_chunk;
    logic             w_partial;
    logic [OUT_W-1:0] w_ext_word;

    // Handshakes depend only on the registered state, never on the peer's ready/valid.
    assign w_in_xfer    = i_in_valid  && (r_state == PK_FILL);
    assign w_out_xfer   = i_out_ready && (r_state == PK_HOLD);
    assign w_last_chunk = (r_cnt == CW'(RATIO - 1));
    assign w_partial    = (r_cnt != CW'(RATIO));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= PK_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            PK_FILL: begin
                if ((w_in_xfer && (w_last_chunk || i_flush)) ||
                    (i_flush && (r_cnt != '0))) begin
                    w_next_state = PK_HOLD;
                end
            end
            PK_HOLD: begin
                if (w_out_xfer) begin
                    w_next_state = PK_FILL;
                end
            end
            default: w_next_state = PK_FILL;
        endcase
    end

    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_out_data  = '0;
        o_out_cnt   = '0;
        case (r_state)
            PK_FILL: o_in_ready = 1'b1;
            PK_HOLD: begin
                o_out_valid = 1'b1;
                o_out_data  = w_ext_word;
                o_out_cnt   = r_cnt;
            end
            default: o_in_ready = 1'b0;
        endcase
    end

    // Chunk data is only sampled on an accepted transfer, so idle-cycle X never lands in r_word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (w_out_xfer) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (w_in_xfer) begin
            for (int j = 0; j < RATIO; j++) begin
                if (r_cnt == CW'(j)) begin
                    r_word[j*IN_W +: IN_W] <= i_in_data;
                end
            end
            r_cnt <= r_cnt + CW'(1);
        end
    end

    io_pack_extend #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_extend (
        .i_word    (r_word),
        .i_cnt     (r_cnt),
        .i_partial (w_partial),
        .o_word    (w_ext_word)
    );

endmodule

// File: doc/io_nibble_packer.md
Name: io_nibble_packer

Overview:
- Parametrised successor to the fixed 4-to-16 zero-extending IO buffer.
- Packs a stream of IN_W-bit chunks, least-significant chunk first, into OUT_W-bit words, with valid/ready handshakes on both sides.
- A FLUSH request emits a partially filled word, zero-extended by default; see the Optional Feature for sign extension.
- Sits between the 4-bit ultra-IO port and the DLX 16-bit word-side datapath.

Parameters:
- IN_W, 4, input chunk width in bits.
- OUT_W, 16, output word width in bits; must be an integer multiple of IN_W, and OUT_W/IN_W >= 2.
- RATIO, OUT_W/IN_W, derived local constant, not overridable: number of chunks per word.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_DATA  input  IN_W  chunk data.
- IN_VALID  input  1  IN_DATA is valid this cycle.
- IN_READY  output  1  packer accepts a chunk this cycle.
- FLUSH  input  1  single-cycle request to emit the partial word.
- OUT_DATA  output  OUT_W  assembled word.
- OUT_VALID  output  1  OUT_DATA is valid.
- OUT_READY  input  1  consumer accepts the word.
- OUT_CNT  output  $clog2(RATIO+1)  number of real chunks in OUT_DATA, range 1..RATIO while OUT_VALID.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=FILL, chunk count=0, word register=0.
  - OUT_VALID=0, OUT_DATA=0, OUT_CNT=0, IN_READY=1 after release.
- Input transfer: IN_VALID && IN_READY on a rising edge.
- Output transfer: OUT_VALID && OUT_READY on a rising edge.
- State FILL:
  - IN_READY=1, OUT_VALID=0.
  - On input transfer, chunk k (0-based count) is written to word bits [k*IN_W +: IN_W], and count increments.
  - If the accepted chunk is number RATIO-1, go to HOLD next cycle with OUT_VALID=1 and OUT_CNT=RATIO.
  - FLUSH with count>0 and no input transfer: go to HOLD with OUT_CNT=count; unfilled upper bits are 0.
  - FLUSH in the same cycle as an input transfer: the chunk is included first, then the word is emitted with OUT_CNT=count+1. If that chunk completes the word, the result equals a normal full word.
  - FLUSH with count=0 and no input transfer: ignored, no empty word is ever emitted.
- State HOLD:
  - IN_READY=0. OUT_DATA and OUT_CNT are held stable while OUT_VALID=1 and OUT_READY=0.
  - FLUSH is ignored.
  - On output transfer: next cycle state=FILL, count=0, word register cleared to 0, OUT_VALID=0, OUT_CNT=0.
- Throughput: one word per RATIO+1 cycles, given continuous input and OUT_READY=1.
- Latency: last-chunk accept edge to OUT_VALID=1 is 1 cycle.
- No combinational path from OUT_READY to IN_READY or from IN_VALID to OUT_VALID; every output is a register or decodes state only.
- Reset mid-word or mid-HOLD discards all partial data immediately (asynchronous).
- IN_DATA is ignored when IN_VALID=0; X on IN_DATA must not propagate into the word register.

Optional Feature:
- Macro: IO_PACKER_SIGN_EXT_EN.
- Defined: on a flushed partial word, bits above the last real chunk are filled with the MSB of that chunk (sign extension). Full words are unaffected.
- Undefined: those bits are 0 (zero extension), identical to the legacy buffer's behaviour for a single chunk.

Decomposition:
- Shared package io_pkg holds:
  - localparams IO_IN_W=4 and IO_OUT_W=16;
  - the packer state enum (PK_FILL, PK_HOLD);
  - a function returning the chunk-count width from RATIO.
- Sub-module io_pack_extend (combinational): takes the word register, count and mode, and returns the zero- or sign-extended word. It is the only place the macro is tested.

Test Plan:
- Full word: feed 0x1,0x2,0x3,0x4 on consecutive cycles with OUT_READY=1 -> OUT_DATA=0x4321, OUT_CNT=4, OUT_VALID high for 1 cycle, IN_READY low in that same cycle.
- Flush partial: feed 0x9, then FLUSH -> OUT_DATA=0x0009, OUT_CNT=1. Rebuild with IO_PACKER_SIGN_EXT_EN -> OUT_DATA=0xFFF9.
- Same-cycle flush: feed 0x5 (count=1), then 0xA with FLUSH asserted in the same cycle -> OUT_DATA=0x00A5 (0xFFA5 with the macro), OUT_CNT=2.
- Backpressure: complete 0xBEEF and hold OUT_READY=0 for 5 cycles while IN_VALID=1 -> OUT_DATA stable at 0xBEEF, IN_READY=0 throughout. Release OUT_READY -> FILL on the next cycle, new chunks packed from bit 0.
- Ignored flush: FLUSH with count=0 -> OUT_VALID stays 0. FLUSH during HOLD -> no effect on OUT_DATA or OUT_CNT.
- Reset mid-word: feed 0x1,0x2, assert RST_N=0 asynchronously between edges -> outputs go to 0 immediately. After release, 0x7,0x6,0x5,0x4 -> OUT_DATA=0x4567.
